tile_frame_writer: RTL and testbench
====================================

TILE_FRAME_WRITER -- requirements
Module: tile_frame_writer

Interface
REQ-001 Parameter TILES, default 320, is the tiles per frame (16 columns x 20 rows of 40x24-pixel tiles); legal range 1..1024.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system/pixel clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 scan_h  in  10  current VGA horizontal scan position, same value the read side of the ping-pong buffer sees.
REQ-006 scan_v  in  10  current VGA vertical scan position.
REQ-007 in_valid  in  1  upstream tile-color beat valid.
REQ-008 in_data  in  8  upstream tile color byte.
REQ-009 in_ready  out  1  block accepts the beat this cycle.
REQ-010 color_adder  in  7  unsigned color offset, sampled with each accepted beat.
REQ-011 addr_write  out  10  tile index driven to the ping-pong buffer write port.
REQ-012 data_write  out  8  tile color driven to the ping-pong buffer write port.
REQ-013 done  out  1  current write buffer holds a complete frame.
REQ-014 underrun  out  1  sticky: a buffer swap occurred before the frame was complete.
REQ-015 frame_count  out  8  number of swaps that began a new fill, mod 256.

Function
REQ-016 swap is internal and combinational: swap = (scan_h == 0) && (scan_v == 0); it marks the cycle where the buffer controller exchanges read and write RAMs.
REQ-017 State machine states: IDLE, FILL, FULL.
REQ-018 IDLE -> FILL on swap; FILL -> FULL on acceptance of beat index TILES-1; FULL -> FILL on swap; FILL -> FILL on swap (restart).
REQ-019 in_ready = (state == FILL) && !swap; IDLE and FULL never accept.
REQ-020 Beat accepted when in_valid && in_ready; tile counter (10 bits) increments by 1 per accepted beat, never exceeds TILES-1.
REQ-021 Latency: beat accepted at cycle N drives addr_write = counter value and data_write at cycle N+1 (registered outputs).
REQ-022 addr_write and data_write hold their last values when no beat is accepted (write port is always enabled; rewrite of identical data is harmless).
REQ-023 data_write arithmetic: 8-bit modulo sum, in_data + zero-extended color_adder, wrap without saturation (see REQ-031).
REQ-024 On swap in any state other than IDLE-before-first-swap: counter cleared to 0, state FILL, frame_count increments by 1 (wraps 255 -> 0).
REQ-025 On swap from IDLE: same as REQ-024 (first frame counted).
REQ-026 Swap while in FILL with counter != 0 or no beat yet: underrun set to 1 and held until reset.
REQ-027 Swap and in_valid in the same cycle: swap wins, beat not accepted (in_ready low), upstream must hold beat.
REQ-028 done = 1 exactly while state == FULL; cleared in the cycle after swap.

Reset
REQ-029 Reset synchronous, active-high, priority over all other inputs including swap.
REQ-030 Reset values: state IDLE, in_ready 0, counter 0, addr_write 0, data_write 0, done 0, underrun 0, frame_count 0; reset mid-FILL discards partial frame without setting underrun.

Configuration
REQ-031 Macro TILE_FRAME_WRITER_COLOR_ADD_EN: defined -> data_write = in_data + color_adder (REQ-023); undefined -> data_write = in_data, color_adder ignored, all other behaviour identical.

Verification
REQ-032 Reset then scan (0,0) one cycle -> state FILL, frame_count 1, in_ready 1 next cycle, underrun 0.
REQ-033 Stream 320 beats in_data=0x10, color_adder=0x05 (macro defined) -> addr_write 0..319 one cycle after each accept, data_write 0x15, done 1 after beat 319, in_ready 0.
REQ-034 in_data=0xFE, color_adder=0x7F (macro defined) -> data_write 0x7D; macro undefined -> 0xFE.
REQ-035 Swap after 100 beats -> underrun 1 sticky, counter restarts, next accepted beat yields addr_write 0, frame_count increments.
REQ-036 in_valid high on swap cycle during FILL -> in_ready 0, no accept that cycle, beat accepted next cycle at addr_write 0.
REQ-037 Reset asserted mid-FILL at beat 50 -> all outputs at reset values next cycle, underrun 0, IDLE until next swap.

Source files
------------

// File: rtl/tile_frame_writer_if.sv
// Tile-color stream, VGA scan position and ping-pong write-port bundle for tile_frame_writer.
interface tile_frame_writer_if;
  localparam int unsigned SCAN_W = 10;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADD_W  = 7;

  logic [SCAN_W-1:0] scan_h;
  logic [SCAN_W-1:0] scan_v;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADD_W-1:0]  color_adder;
  logic [ADDR_W-1:0] addr_write;
  logic [DATA_W-1:0] data_write;
  logic              done;
  logic              underrun;
  logic [DATA_W-1:0] frame_count;

  modport master (
    output scan_h, scan_v, in_valid, in_data, color_adder,
    input  in_ready, addr_write, data_write, done, underrun, frame_count
  );

  modport slave (
    input  scan_h, scan_v, in_valid, in_data, color_adder,
    output in_ready, addr_write, data_write, done, underrun, frame_count
  );
endinterface

// File: rtl/tile_frame_writer.sv
// Fills the write half of a tile ping-pong buffer with one color per tile, restarting on each buffer swap.
// Optional macro TILE_FRAME_WRITER_COLOR_ADD_EN adds color_adder to every written color.
module tile_frame_writer #(
  parameter int unsigned TILES = 320
) (
  input logic                clk,
  input logic                reset,
  tile_frame_writer_if.slave bus
);
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] LAST_IDX = AW'(TILES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t        r_state,    w_state_nxt;
  logic [AW-1:0] r_cnt,      w_cnt_nxt;
  logic [AW-1:0] r_addr,     w_addr_nxt;
  logic [DW-1:0] r_data,     w_data_nxt;
  logic [DW-1:0] r_frames,   w_frames_nxt;
  logic          r_underrun, w_underrun_nxt;
  logic          w_swap;
  logic          w_ready;
  logic          w_accept;
  logic [DW-1:0] w_pix;

  // Swap happens at scan origin; it always beats a same-cycle beat.
  assign w_swap   = (bus.scan_h == '0) && (bus.scan_v == '0);
  assign w_ready  = (r_state == FILL) && !w_swap;
  assign w_accept = bus.in_valid && w_ready;

`ifdef TILE_FRAME_WRITER_COLOR_ADD_EN
  assign w_pix = bus.in_data + DW'(bus.color_adder);
`else
  assign w_pix = bus.in_data;
`endif

  // Next-state and write-port update.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_frames_nxt   = r_frames;
    w_underrun_nxt = r_underrun;

    if (w_swap) begin
      w_state_nxt  = FILL;
      w_cnt_nxt    = '0;
      w_frames_nxt = r_frames + DW'(1);
      if (r_state == FILL) begin
        w_underrun_nxt = 1'b1;
      end
    end else if (w_accept) begin
      w_addr_nxt = r_cnt;
      w_data_nxt = w_pix;
      if (r_cnt == LAST_IDX) begin
        w_state_nxt = FULL;
      end else begin
        w_cnt_nxt = r_cnt + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_frames   <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_frames   <= w_frames_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.addr_write  = r_addr;
  assign bus.data_write  = r_data;
  assign bus.done        = (r_state == FULL);
  assign bus.underrun    = r_underrun;
  assign bus.frame_count = r_frames;
endmodule

// File: tb/tb_tile_frame_writer.sv
// Scoreboard bench for tile_frame_writer: stimulus queues expected write-port values, a monitor checks them.
module tb_tile_frame_writer;
  logic clk = 1'b0;
  logic reset;

  tile_frame_writer_if bus();

  tile_frame_writer #(.TILES(320)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         vecs  = 0;
  int         fails = 0;
  logic [9:0] model_idx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Hold a beat until the DUT is ready, queueing the expected write for that accept.
  task automatic beat(input logic [7:0] d, input logic [6:0] a);
    int   guard;
    exp_t e;
    guard           = 0;
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.color_adder = a;
    #1;
    while (!bus.in_ready && guard < 20) begin
      step();
      #1;
      guard++;
    end
    if (!bus.in_ready) begin
      chk("beat_ready_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      e.addr = model_idx;
      e.data = d;
`ifdef TILE_FRAME_WRITER_COLOR_ADD_EN
      e.data = d + {1'b0, a};
`endif
      exp_q.push_back(e);
      model_idx = model_idx + 10'd1;
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_swap();
    bus.scan_h = '0;
    bus.scan_v = '0;
    #1;
    chk("ready_on_swap", 32'(bus.in_ready), 32'd0);
    step();
    bus.scan_h = 10'd1;
    bus.scan_v = 10'd1;
    model_idx  = '0;
  endtask

  // Monitor: compare the write port after every edge against the scoreboard or its held value.
  initial begin
    logic       s_rst;
    logic       s_acc;
    logic [9:0] last_a;
    logic [7:0] last_d;
    exp_t       e;
    last_a = '0;
    last_d = '0;
    forever begin
      @(negedge clk);
      s_rst = reset;
      s_acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (s_rst) begin
        last_a = '0;
        last_d = '0;
        chk("addr_reset", 32'(bus.addr_write), 32'd0);
        chk("data_reset", 32'(bus.data_write), 32'd0);
      end else if (s_acc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("addr_write", 32'(bus.addr_write), 32'(e.addr));
          chk("data_write", 32'(bus.data_write), 32'(e.data));
          last_a = e.addr;
          last_d = e.data;
        end
      end else begin
        chk("addr_hold", 32'(bus.addr_write), 32'(last_a));
        chk("data_hold", 32'(bus.data_write), 32'(last_d));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.scan_h      = 10'd1;
    bus.scan_v      = 10'd1;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.color_adder = '0;
    repeat (3) step();
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_underrun", 32'(bus.underrun), 32'd0);
    chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
    reset = 1'b0;

    bus.in_valid = 1'b1;
    #1;
    chk("idle_no_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.in_valid = 1'b0;

    // First swap starts frame 1.
    do_swap();
    #1;
    chk("first_fc", 32'(bus.frame_count), 32'd1);
    chk("first_ready", 32'(bus.in_ready), 32'd1);
    chk("first_underrun", 32'(bus.underrun), 32'd0);
    chk("first_done", 32'(bus.done), 32'd0);

    repeat (320) beat(8'h10, 7'h05);
    #1;
    chk("full_done", 32'(bus.done), 32'd1);
    chk("full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    repeat (3) step();
    #1;
    chk("full_no_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    // Swap from FULL: new frame without underrun.
    do_swap();
    #1;
    chk("swap_full_done", 32'(bus.done), 32'd0);
    chk("swap_full_fc", 32'(bus.frame_count), 32'd2);
    chk("swap_full_underrun", 32'(bus.underrun), 32'd0);

    beat(8'hFE, 7'h7F);
    beat(8'hFF, 7'h01);
    repeat (98) beat(8'h3C, 7'h11);
    chk("pre_underrun", 32'(bus.underrun), 32'd0);
    do_swap();
    #1;
    chk("underrun_set", 32'(bus.underrun), 32'd1);
    chk("underrun_fc", 32'(bus.frame_count), 32'd3);
    chk("underrun_done", 32'(bus.done), 32'd0);

    // Beat presented on a swap cycle is held and lands at tile 0.
    bus.scan_h      = '0;
    bus.scan_v      = '0;
    bus.in_valid    = 1'b1;
    bus.in_data     = 8'hA5;
    bus.color_adder = 7'h0A;
    #1;
    chk("swap_beat_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.scan_h = 10'd1;
    bus.scan_v = 10'd1;
    model_idx  = '0;
    beat(8'hA5, 7'h0A);
    chk("swap_beat_fc", 32'(bus.frame_count), 32'd4);
    chk("underrun_sticky", 32'(bus.underrun), 32'd1);
    repeat (49) beat(8'h20, 7'h02);

    // Reset mid-frame, coinciding with a swap and a pending beat.
    reset        = 1'b1;
    bus.scan_h   = '0;
    bus.scan_v   = '0;
    bus.in_valid = 1'b1;
    step();
    reset      = 1'b0;
    bus.scan_h = 10'd1;
    bus.scan_v = 10'd1;
    #1;
    chk("midrst_fc", 32'(bus.frame_count), 32'd0);
    chk("midrst_underrun", 32'(bus.underrun), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_ready", 32'(bus.in_ready), 32'd0);
    step();
    #1;
    chk("midrst_idle_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    do_swap();
    #1;
    chk("post_rst_fc", 32'(bus.frame_count), 32'd1);
    chk("post_rst_underrun", 32'(bus.underrun), 32'd0);
    beat(8'h01, 7'h00);

    // frame_count wraps 255 -> 0.
    repeat (255) do_swap();
    #1;
    chk("fc_wrap", 32'(bus.frame_count), 32'd0);
    chk("wrap_underrun", 32'(bus.underrun), 32'd1);

    repeat (3) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
